flagged_pkt_tx: RTL and testbench
=================================

// Module: flagged_pkt_tx
// PURPOSE
// Avalon-ST source that replays packets the sniffer has flagged and stored in the packet buffer RAM.
// Takes one packet descriptor (start word address, byte length) at a time.
// Reads the packet words from the buffer's synchronous read port and streams them out on the MAC TX interface.
// Sits between the packet buffer/descriptor queue and the MAC TX side; the transmit counterpart of the RX controller.
// PARAMETERS
// ADDR_W   10    packet buffer word-address width; buffer depth 2**ADDR_W 32-bit words
// MAX_LEN  1518  largest byte length transmitted; longer descriptors are dropped
// IPG      3     idle cycles (tx_valid low) forced after each eop beat
// PORTS
// clk            in   1       clock
// n_rst          in   1       reset, asynchronous, active-low
// desc_valid     in   1       descriptor present
// desc_ready     out  1       block accepts descriptor (handshake: desc_valid & desc_ready at edge)
// desc_addr      in   ADDR_W  first word address of packet in buffer
// desc_len       in   16      packet length in bytes
// mem_rd_en      out  1       buffer read strobe; mem_rdata valid exactly 1 cycle later
// mem_raddr      out  ADDR_W  buffer read address
// mem_rdata      in   32      buffer read data; first byte on [31:24]
// tx_valid       out  1       beat valid
// tx_ready       in   1       MAC accepts beat (transfer = tx_valid & tx_ready)
// tx_data        out  32      beat data; first byte on [31:24]
// tx_sop         out  1       first beat of packet
// tx_eop         out  1       last beat of packet
// tx_empty       out  2       unused bytes in eop beat; 0 on non-eop beats
// tx_error       out  1       always 0; reserved
// tx_pkt_count   out  32      packets fully sent (eop beat transferred), wraps at 2**32
// tx_drop_count  out  32      descriptors dropped (len 0 or > MAX_LEN), wraps at 2**32
// busy           out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset values:
//   - Registered outputs: 0 (tx_valid, tx_sop, tx_eop, tx_empty, tx_data, counts, mem_rd_en, mem_raddr).
//   - State: IDLE, so desc_ready = 1 and busy = 0.
// - Reset mid-packet: packet abandoned, no eop emitted, output FIFO and in-flight reads discarded; MAC is reset together.
// - FSM states and transitions:
//   - IDLE: desc_ready = 1.
//     - On accept with len 0 or len > MAX_LEN: tx_drop_count + 1, stay IDLE.
//     - Otherwise: latch addr; words = ceil(len/4); last_empty = (4 - len%4)%4; go to READ.
//   - READ: issue one read per cycle while (FIFO occupancy + reads in flight) < 4.
//     - mem_raddr = latched addr + k, modulo 2**ADDR_W (wraps from 2**ADDR_W-1 to 0).
//     - After issuing words reads, go to DRAIN.
//   - DRAIN: wait until the eop beat transfers, then go to GAP.
//   - GAP: count IPG cycles with tx_valid = 0, then go to IDLE.
//   - desc_ready = 0 in READ, DRAIN and GAP.
// - Output path: returning mem_rdata pushed into a 4-entry FIFO, tagged with sop/eop/empty; FIFO head drives tx_*.
//   - Credit rule guarantees the FIFO never overflows.
// - Avalon-ST rules:
//   - tx_data, tx_sop, tx_eop and tx_empty hold stable while tx_valid & !tx_ready.
//   - tx_valid never drops without a transfer.
//   - tx_sop and tx_eop both high on a 1-word packet.
// - Latency: descriptor accepted at edge E0 -> first mem_rd_en in cycle after E0 -> tx_valid high after edge E2.
// - Throughput: with tx_ready held high, one beat per cycle, no bubbles inside a packet.
// - tx_pkt_count increments on the edge where the eop beat transfers.
// - tx_drop_count increments on the accept edge.
// - Descriptors presented in GAP are held off (desc_ready = 0) and accepted in IDLE.
// TESTING
// - len 64 at addr 0x010, tx_ready=1 -> 16 beats at addresses 0x010..0x01F; sop on beat 1, eop on beat 16; empty=0; pkt_count=1; 3 idle cycles follow.
// - len 61 -> 16 beats, eop beat tx_empty=3; len 1 -> single beat with sop=eop=1, tx_empty=3.
// - addr 0x3FE, len 16, ADDR_W=10 -> reads at 0x3FE, 0x3FF, 0x000, 0x001; data order preserved.
// - tx_ready toggled 1010... and held low 5 cycles mid-packet -> tx_* stable while stalled; no beat lost or duplicated; FIFO never exceeds 4.
// - len 0 then len 2000 -> drop_count=2, no tx_valid, desc_ready stays 1.
// - n_rst pulsed low on beat 5 of 16 -> all outputs 0 immediately; next descriptor transmits cleanly from sop.

Source files
------------

// File: rtl/flagged_pkt_tx.sv
// Replays flagged packets from the packet buffer onto the MAC TX Avalon-ST port.
// One descriptor at a time; reads are credit-limited so the 4-entry output FIFO cannot overflow.
module flagged_pkt_tx #(
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 1518,
  parameter int IPG     = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [15:0]       desc_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [1:0]        tx_empty,
  output logic              tx_error,
  output logic [31:0]       tx_pkt_count,
  output logic [31:0]       tx_drop_count,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_e;
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [1:0] empty;
  } tag_t;

  localparam int          GAP_W     = (IPG > 1) ? $clog2(IPG) : 1;
  localparam logic [16:0] MAX_LEN_V = 17'(MAX_LEN);

  state_e            state_q, state_d;
  logic [14:0]       words_q, issued_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        last_empty_q;
  logic [GAP_W-1:0]  gap_q;
  logic              rd_en_q, rvalid_q;
  logic [ADDR_W-1:0] raddr_q;
  tag_t              rd_tag_q, rvalid_tag_q;
  logic [31:0]       fifo_data [4];
  tag_t              fifo_tag  [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q;
  logic [31:0]       pkt_cnt_q, drop_cnt_q;

  logic              accept, drop, issue, push, pop, desc_bad;
  logic [14:0]       desc_words;
  logic [1:0]        desc_empty;
  logic [3:0]        credit_used;
  logic [ADDR_W-1:0] issue_addr;
  tag_t              issue_tag, head_tag;

  assign head_tag    = fifo_tag[rd_ptr_q];
  assign tx_valid    = (cnt_q != 3'd0);
  assign push        = rvalid_q;
  assign pop         = tx_valid & tx_ready;
  assign desc_words  = 15'((17'(desc_len) + 17'd3) >> 2);
  assign desc_empty  = 2'(3'd4 - {1'b0, desc_len[1:0]});
  assign desc_bad    = (desc_len == 16'd0) || ({1'b0, desc_len} > MAX_LEN_V);
  // FIFO entries plus reads still on their way back from the buffer
  assign credit_used = 4'(cnt_q) + 4'(rd_en_q) + 4'(rvalid_q);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    drop       = 1'b0;
    issue      = 1'b0;
    issue_addr = base_q + ADDR_W'(issued_q);
    issue_tag  = '0;
    case (state_q)
      IDLE: begin
        if (desc_valid) begin
          accept = 1'b1;
          if (desc_bad) begin
            drop = 1'b1;
          end else begin
            issue           = 1'b1;
            issue_addr      = desc_addr;
            issue_tag.sop   = 1'b1;
            issue_tag.eop   = (desc_words == 15'd1);
            issue_tag.empty = (desc_words == 15'd1) ? desc_empty : 2'd0;
            state_d         = (desc_words == 15'd1) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (credit_used < 4'd4) begin
          issue           = 1'b1;
          issue_tag.eop   = (15'(issued_q + 15'd1) == words_q);
          issue_tag.empty = issue_tag.eop ? last_empty_q : 2'd0;
          if (issue_tag.eop) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_tag.eop) state_d = (IPG == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_q == GAP_W'(IPG - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_en_q    <= 1'b0;
      raddr_q    <= '0;
      rvalid_q   <= 1'b0;
      issued_q   <= '0;
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_en_q  <= issue;
      rvalid_q <= rd_en_q;
      if (issue) raddr_q <= issue_addr;
      if (accept && !drop) issued_q <= 15'd1;
      else if (issue)      issued_q <= 15'(issued_q + 15'd1);
      gap_q <= (state_q == GAP) ? GAP_W'(gap_q + GAP_W'(1)) : '0;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q <= cnt_q + 3'(push) - 3'(pop);
      if (pop && head_tag.eop) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (drop)                drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  // Datapath and per-packet parameters: only read when qualified by control state.
  always_ff @(posedge clk) begin
    if (accept && !drop) begin
      base_q       <= desc_addr;
      words_q      <= desc_words;
      last_empty_q <= desc_empty;
    end
    if (issue) rd_tag_q <= issue_tag;
    rvalid_tag_q <= rd_tag_q;
    if (push) begin
      fifo_data[wr_ptr_q] <= mem_rdata;
      fifo_tag[wr_ptr_q]  <= rvalid_tag_q;
    end
  end

  assign tx_data       = tx_valid ? fifo_data[rd_ptr_q] : 32'd0;
  assign tx_sop        = tx_valid & head_tag.sop;
  assign tx_eop        = tx_valid & head_tag.eop;
  assign tx_empty      = tx_valid ? head_tag.empty : 2'd0;
  assign tx_error      = 1'b0;
  assign mem_rd_en     = rd_en_q;
  assign mem_raddr     = raddr_q;
  assign tx_pkt_count  = pkt_cnt_q;
  assign tx_drop_count = drop_cnt_q;
  assign desc_ready    = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_flagged_pkt_tx.sv
// Bench for flagged_pkt_tx: a descriptor-level model expands each accepted packet
// into expected read addresses and beats, checked every cycle against the DUT.
`timescale 1ns/1ps
module tb_flagged_pkt_tx;
  localparam int ADDR_W  = 10;
  localparam int MAX_LEN = 1518;
  localparam int IPG     = 3;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              desc_valid, desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [15:0]       desc_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              tx_valid, tx_ready;
  logic [31:0]       tx_data;
  logic              tx_sop, tx_eop, tx_error, busy;
  logic [1:0]        tx_empty;
  logic [31:0]       tx_pkt_count, tx_drop_count;

  flagged_pkt_tx #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .IPG(IPG)) dut (
    .clk(clk), .n_rst(n_rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty), .tx_error(tx_error),
    .tx_pkt_count(tx_pkt_count), .tx_drop_count(tx_drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_raddr];

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t             exp_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [31:0]       data_log[$];

  int n_chk = 0, n_fail = 0;
  int pkt_cnt, drop_cnt, gap_left, reads_out, cyc, acc_cyc, lat_rd, lat_v;
  int beats_pkt, beats_total, first_beat_cyc, last_beat_cyc, gap_meas, since_eop;
  int rmode, stall_at, stall_left;
  bit pkt_active, prev_stall, acc_seen, first_rd_seen, first_v_seen, gap_counting, one_beat;
  logic [1:0] last_empty_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); rd_q.delete(); rd_log.delete(); data_log.delete();
    pkt_cnt = 0; drop_cnt = 0; gap_left = 0; reads_out = 0;
    pkt_active = 0; prev_stall = 0; gap_counting = 0; since_eop = 1000;
  endtask

  task automatic monitor();
    bit                exp_rdy;
    beat_t             b;
    int                words;
    logic [ADDR_W-1:0] a, ea;
    cyc++;
    exp_rdy = !pkt_active && gap_left == 0;
    check("desc_ready", 32'(desc_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(!exp_rdy));
    check("tx_error", 32'(tx_error), 32'd0);
    check("tx_pkt_count", tx_pkt_count, 32'(pkt_cnt));
    check("tx_drop_count", tx_drop_count, 32'(drop_cnt));
    if (gap_counting) begin
      if (!desc_ready) gap_meas++;
      else gap_counting = 0;
    end
    if (!pkt_active && gap_left > 0) gap_left--;

    if (mem_rd_en) begin
      reads_out++;
      if (!first_rd_seen) begin first_rd_seen = 1; lat_rd = cyc - acc_cyc; end
      rd_log.push_back(mem_raddr);
      check("read_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        ea = rd_q.pop_front();
        check("mem_raddr", 32'(mem_raddr), 32'(ea));
      end
      check("outstanding_le_4", 32'(reads_out <= 4), 32'd1);
    end

    if (tx_valid) begin
      if (since_eop < 1000) begin
        check("ipg_idle_cycles", 32'(since_eop >= IPG), 32'd1);
        since_eop = 1000;
      end
      if (!first_v_seen) begin first_v_seen = 1; lat_v = cyc - acc_cyc; end
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        check("tx_data", tx_data, b.data);
        check("tx_sop", 32'(tx_sop), 32'(b.sop));
        check("tx_eop", 32'(tx_eop), 32'(b.eop));
        check("tx_empty", 32'(tx_empty), 32'(b.empty));
        if (tx_ready) begin
          void'(exp_q.pop_front());
          reads_out--;
          beats_pkt++; beats_total++;
          if (beats_pkt == 1) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
          data_log.push_back(tx_data);
          if (tx_sop && tx_eop) one_beat = 1;
          if (tx_eop) last_empty_seen = tx_empty;
          if (b.eop) begin
            pkt_cnt++; pkt_active = 0; gap_left = IPG;
            gap_counting = 1; gap_meas = 0; since_eop = 0;
          end
        end
      end
    end else begin
      check("valid_held_until_transfer", 32'(prev_stall), 32'd0);
      if (since_eop < 1000) since_eop++;
    end
    prev_stall = tx_valid && !tx_ready;

    if (desc_valid && exp_rdy) begin
      acc_seen = 1;
      if (desc_len == 16'd0 || int'(desc_len) > MAX_LEN) begin
        drop_cnt++;
      end else begin
        words = (int'(desc_len) + 3) / 4;
        pkt_active = 1; acc_cyc = cyc; first_rd_seen = 0; first_v_seen = 0;
        beats_pkt = 0; one_beat = 0;
        rd_log.delete(); data_log.delete();
        for (int k = 0; k < words; k++) begin
          a = ADDR_W'((int'(desc_addr) + k) % DEPTH);
          rd_q.push_back(a);
          b.data  = mem[a];
          b.sop   = (k == 0);
          b.eop   = (k == words - 1);
          b.empty = b.eop ? 2'((4 - int'(desc_len) % 4) % 4) : 2'd0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (n_rst) monitor();
    @(posedge clk);
    #1;
    if (stall_at > 0 && beats_pkt == stall_at) begin stall_left = 5; stall_at = 0; end
    if (stall_left > 0) begin
      tx_ready = 1'b0;
      stall_left--;
    end else begin
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = !tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [15:0] l);
    int n = 0;
    desc_addr = a; desc_len = l; desc_valid = 1'b1; acc_seen = 0;
    while (!acc_seen && n < 3000) begin tick(); n++; end
    check("desc_accepted", 32'(acc_seen), 32'd1);
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pkt_active || gap_left > 0 || exp_q.size() != 0) && n < 5000) begin tick(); n++; end
    check("packet_drained", 32'(pkt_active || gap_left > 0 || exp_q.size() != 0), 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, bt;
    logic [15:0] l;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    n_rst = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_len = '0; tx_ready = 1'b1;
    rmode = 0; stall_at = 0; stall_left = 0; cyc = 0; acc_cyc = 0; beats_total = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    check("rst_desc_ready", 32'(desc_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_count", tx_pkt_count, 32'd0);
    n_rst = 1'b1;
    tick();

    // 64-byte packet at 0x010, MAC always ready
    send(10'h010, 16'd64);
    wait_idle();
    check("t64_beats", 32'(beats_pkt), 32'd16);
    check("t64_first_addr", 32'(rd_log[0]), 32'h010);
    check("t64_last_addr", 32'(rd_log[15]), 32'h01F);
    check("t64_rd_latency", 32'(lat_rd), 32'd1);
    check("t64_valid_latency", 32'(lat_v), 32'd3);
    check("t64_no_bubbles", 32'(last_beat_cyc - first_beat_cyc), 32'd15);
    check("t64_empty", 32'(last_empty_seen), 32'd0);
    check("t64_gap", 32'(gap_meas), 32'd3);
    check("t64_pkt_count", tx_pkt_count, 32'd1);

    send(10'h200, 16'd61);
    wait_idle();
    check("t61_beats", 32'(beats_pkt), 32'd16);
    check("t61_empty", 32'(last_empty_seen), 32'd3);

    send(10'h055, 16'd1);
    wait_idle();
    check("t1_beats", 32'(beats_pkt), 32'd1);
    check("t1_sop_eop", 32'(one_beat), 32'd1);
    check("t1_empty", 32'(last_empty_seen), 32'd3);

    send(10'h3FE, 16'd16);
    wait_idle();
    check("wrap_addr0", 32'(rd_log[0]), 32'h3FE);
    check("wrap_addr1", 32'(rd_log[1]), 32'h3FF);
    check("wrap_addr2", 32'(rd_log[2]), 32'h000);
    check("wrap_addr3", 32'(rd_log[3]), 32'h001);
    check("wrap_data2", data_log[2], mem[0]);
    check("wrap_data3", data_log[3], mem[1]);

    // alternating ready with a 5-cycle stall mid-packet
    rmode = 1; stall_at = 6;
    send(10'h123, 16'd64);
    wait_idle();
    check("stall_beats", 32'(beats_pkt), 32'd16);
    rmode = 0; stall_at = 0;

    bt = beats_total;
    send(10'h000, 16'd0);
    send(10'h000, 16'd2000);
    tick();
    check("drop_count", tx_drop_count, 32'd2);
    check("drop_no_beats", 32'(beats_total), 32'(bt));
    check("drop_ready", 32'(desc_ready), 32'd1);

    send(10'h100, 16'd1518);
    wait_idle();
    check("max_len_beats", 32'(beats_pkt), 32'd380);
    send(10'h100, 16'd1519);
    tick();
    check("over_max_dropped", tx_drop_count, 32'd3);

    // reset in the middle of a packet
    send(10'h010, 16'd64);
    n = 0;
    while (beats_pkt < 5 && n < 100) begin tick(); n++; end
    check("reached_beat5", 32'(beats_pkt), 32'd5);
    n_rst = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", tx_data, 32'd0);
    check("mid_rst_sop_eop", 32'({tx_sop, tx_eop}), 32'd0);
    check("mid_rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_pkt_count", tx_pkt_count, 32'd0);
    check("mid_rst_drop_count", tx_drop_count, 32'd0);
    check("mid_rst_desc_ready", 32'(desc_ready), 32'd1);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    send(10'h040, 16'd16);
    wait_idle();
    check("post_rst_beats", 32'(beats_pkt), 32'd4);
    check("post_rst_pkt_count", tx_pkt_count, 32'd1);

    // randomised traffic with random backpressure, descriptors back to back
    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      l = 16'd0;
      else if (r == 1) l = 16'(1519 + $urandom_range(0, 500));
      else             l = 16'($urandom_range(1, 150));
      send(ADDR_W'($urandom_range(0, DEPTH - 1)), l);
    end
    wait_idle();
    rmode = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
